// File: rtl/a2d_pkg.sv
// Shared types and ADC command-word layout for the a2d_sched conversion scheduler.
package a2d_pkg;

   typedef enum logic [1:0] {
      SLOT_BATT,
      SLOT_CURR,
      SLOT_BRAKE,
      SLOT_TORQUE
   } slot_t;

   typedef enum logic [2:0] {
      IDLE,
      CMD,
      WAIT1,
      GAP,
      RD,
      WAIT2
   } state_t;

   localparam int CHNL_LSB = 11;
   localparam int CHNL_MSB = 13;

   // ADC128S control word: only the channel-select field is ever non-zero.
   function automatic logic [15:0] adc_cmd(input logic [2:0] ch);
      logic [15:0] w;
      w                   = '0;
      w[CHNL_MSB:CHNL_LSB] = ch;
      return w;
   endfunction

endpackage

// File: rtl/a2d_sched_if.sv
// Scheduler-to-SPI-master transaction bus: start pulse plus command out, completion plus read data back.
interface a2d_sched_if;
   logic        wrt;
   logic [15:0] cmd;
   logic        done;
   logic [15:0] rd_data;

   modport master (output wrt, cmd, input done, rd_data);
   modport slave  (input wrt, cmd, output done, rd_data);
endinterface

// File: rtl/a2d_sched_rr_pick.sv
// Round-robin finder: first enabled slot after ptr, wrapping, with ptr's own slot tried last.
module rr_pick
   import a2d_pkg::*;
(
   input  slot_t      ptr_i,
   input  logic [3:0] en_mask_i,
   output slot_t      nxt_o,
   output logic       any_o
);

   logic [1:0] idx;

   // NOTE: every combinational output gets a default first so no path infers a latch.
   always_comb begin
      nxt_o = ptr_i;
      any_o = |en_mask_i;
      idx   = '0;
      // Walk from farthest to nearest so the nearest enabled slot overwrites last.
      for (int k = 4; k >= 1; k--) begin
         idx = ptr_i + 2'(k);
         if (en_mask_i[idx]) begin
            nxt_o = slot_t'(idx);
         end
      end
   end

endmodule

// File: rtl/a2d_sched.sv
// ADC128S conversion scheduler: periodic round-robin over four slots with on-demand priority requests.
module a2d_sched
   import a2d_pkg::*;
#(
   parameter int         PERIOD    = 1024,
   parameter logic [2:0] CH_BATT   = 3'd0,
   parameter logic [2:0] CH_CURR   = 3'd1,
   parameter logic [2:0] CH_BRAKE  = 3'd3,
   parameter logic [2:0] CH_TORQUE = 3'd4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [3:0]        en_mask,
   input  logic              dmd_vld,
   input  logic [1:0]        dmd_slot,
   output logic              dmd_rdy,
   a2d_sched_if.master       spi,
   output logic [11:0]       batt,
   output logic [11:0]       curr,
   output logic [11:0]       brake,
   output logic [11:0]       torque,
   output logic              res_vld,
   output logic [1:0]        res_slot,
   output logic              busy
);

   localparam int TW = $clog2(PERIOD + 1);

   state_t        state_q, state_d;
   logic [TW-1:0] timer_q, timer_d;
   slot_t         ptr_q, ptr_d;
   slot_t         cur_q, cur_d;
   logic [11:0]   res_q [4];
   logic          res_vld_q;
   logic [1:0]    res_slot_q;
   logic          latch;
   logic          due;
   slot_t         pick_nxt;
   logic          pick_any;

   function automatic logic [2:0] ch_of(input slot_t s);
      logic [2:0] ch;
      ch = CH_BATT;
      case (s)
         SLOT_BATT:   ch = CH_BATT;
         SLOT_CURR:   ch = CH_CURR;
         SLOT_BRAKE:  ch = CH_BRAKE;
         SLOT_TORQUE: ch = CH_TORQUE;
      endcase
      return ch;
   endfunction

   rr_pick u_pick (
      .ptr_i     (ptr_q),
      .en_mask_i (en_mask),
      .nxt_o     (pick_nxt),
      .any_o     (pick_any)
   );

   assign due = (timer_q == TW'(PERIOD));

   always_comb begin
      state_d  = state_q;
      timer_d  = '0;
      ptr_d    = ptr_q;
      cur_d    = cur_q;
      dmd_rdy  = 1'b0;
      spi.wrt  = 1'b0;
      spi.cmd  = '0;
      latch    = 1'b0;
      case (state_q)
         IDLE: begin
            dmd_rdy = 1'b1;
            timer_d = due ? timer_q : timer_q + TW'(1);
            if (dmd_vld) begin
               cur_d   = slot_t'(dmd_slot);
               state_d = CMD;
            end else if (due && pick_any) begin
               cur_d   = pick_nxt;
               ptr_d   = pick_nxt;
               state_d = CMD;
            end
         end
         CMD: begin
            spi.wrt = 1'b1;
            spi.cmd = adc_cmd(ch_of(cur_q));
            state_d = WAIT1;
         end
         WAIT1: if (spi.done) state_d = GAP;
         GAP:   state_d = RD;
         RD: begin
            spi.wrt = 1'b1;
            spi.cmd = adc_cmd(ch_of(cur_q));
            state_d = WAIT2;
         end
         WAIT2: begin
            if (spi.done) begin
               latch   = 1'b1;
               state_d = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so all registers update together.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q    <= IDLE;
         timer_q    <= '0;
         ptr_q      <= SLOT_TORQUE;   // next pick after TORQUE wraps to BATT
         cur_q      <= SLOT_BATT;
         res_vld_q  <= 1'b0;
         res_slot_q <= '0;
         // NOTE: the result array is small and architecturally visible, so it is reset like any register.
         for (int k = 0; k < 4; k++) res_q[k] <= '0;
      end else begin
         state_q   <= state_d;
         timer_q   <= timer_d;
         ptr_q     <= ptr_d;
         cur_q     <= cur_d;
         res_vld_q <= latch;
         if (latch) begin
            res_q[cur_q] <= spi.rd_data[11:0];
            res_slot_q   <= cur_q;
         end
      end
   end

   assign batt     = res_q[SLOT_BATT];
   assign curr     = res_q[SLOT_CURR];
   assign brake    = res_q[SLOT_BRAKE];
   assign torque   = res_q[SLOT_TORQUE];
   assign res_vld  = res_vld_q;
   assign res_slot = res_slot_q;
   assign busy     = (state_q != IDLE);

endmodule

// File: tb/tb_a2d_sched.sv
// Directed bench for a2d_sched: SPI slave model plus command/result scoreboard checked every cycle.
module tb_a2d_sched;

   localparam int P = 16;

   typedef struct {
      logic [1:0]  slot;
      logic [11:0] data;
   } exp_res_t;

   logic        clk;
   logic        rst;
   logic [3:0]  en_mask;
   logic        dmd_vld;
   logic [1:0]  dmd_slot;
   logic        dmd_rdy;
   logic [11:0] batt, curr, brake, torque;
   logic        res_vld;
   logic [1:0]  res_slot;
   logic        busy;

   logic        done_m, done_man;
   logic [15:0] rd_m;
   bit          hold_rd;

   int          n_checks;
   int          n_errors;
   int          cyc;
   int          last_first;
   bit          first_par;
   bit          chk_spacing;
   bit          idle_phase;

   logic [15:0] exp_cmd_q [$];
   exp_res_t    exp_res_q [$];

   a2d_sched_if bus ();

   assign bus.done    = done_m | done_man;
   assign bus.rd_data = done_man ? 16'hFABC : rd_m;

   a2d_sched #(.PERIOD(P)) dut (
      .clk      (clk),
      .rst      (rst),
      .en_mask  (en_mask),
      .dmd_vld  (dmd_vld),
      .dmd_slot (dmd_slot),
      .dmd_rdy  (dmd_rdy),
      .spi      (bus.master),
      .batt     (batt),
      .curr     (curr),
      .brake    (brake),
      .torque   (torque),
      .res_vld  (res_vld),
      .res_slot (res_slot),
      .busy     (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [2:0] ch_tbl(input int slot);
      case (slot)
         0:       return 3'd0;
         1:       return 3'd1;
         2:       return 3'd3;
         default: return 3'd4;
      endcase
   endfunction

   function automatic logic [11:0] data_for(input logic [2:0] ch);
      case (ch)
         3'd0:    return 12'hC00;
         3'd1:    return 12'hBF1;
         3'd3:    return 12'hBE3;
         3'd4:    return 12'hBD4;
         default: return 12'h000;
      endcase
   endfunction

   function automatic logic [11:0] res_port(input logic [1:0] slot);
      case (slot)
         2'd0:    return batt;
         2'd1:    return curr;
         2'd2:    return brake;
         default: return torque;
      endcase
   endfunction

   // SPI master model: done two cycles after each wrt; rd_data carries junk in the top nibble.
   initial begin
      int          wcnt;
      logic [2:0]  ch;
      bit          second;
      done_m = 1'b0;
      rd_m   = '0;
      wcnt   = 0;
      forever begin
         @(negedge clk);
         if (bus.wrt === 1'b1) begin
            ch     = bus.cmd[13:11];
            second = wcnt[0];
            wcnt++;
            if (!(hold_rd && second)) begin
               repeat (2) @(negedge clk);
               done_m = 1'b1;
               rd_m   = {4'hA, data_for(ch)};
               @(negedge clk);
               done_m = 1'b0;
               rd_m   = 16'h5555;
            end
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   task automatic push_conv(input int slot, input bit with_res = 1'b1);
      logic [15:0] c;
      exp_res_t    r;
      c = {2'b00, ch_tbl(slot), 11'h000};
      exp_cmd_q.push_back(c);
      exp_cmd_q.push_back(c);
      if (with_res) begin
         r.slot = 2'(slot);
         r.data = data_for(ch_tbl(slot));
         exp_res_q.push_back(r);
      end
   endtask

   // One clock, then scoreboard every DUT output event seen at the falling edge.
   task automatic tick();
      logic [15:0] ec;
      exp_res_t    er;
      @(negedge clk);
      cyc++;
      if (rst) first_par = 1'b1;
      if (bus.wrt === 1'b1) begin
         if (exp_cmd_q.size() > 0) begin
            ec = exp_cmd_q.pop_front();
            check("cmd", 32'(bus.cmd), 32'(ec));
         end else begin
            check("unexpected_wrt", 32'(bus.wrt), 32'd0);
         end
         if (first_par) begin
            if (chk_spacing && last_first >= 0)
               check("first_wrt_spacing_ok", 32'((cyc - last_first) >= P), 32'd1);
            last_first = cyc;
         end
         first_par = ~first_par;
      end
      if (res_vld === 1'b1) begin
         if (exp_res_q.size() > 0) begin
            er = exp_res_q.pop_front();
            check("res_slot", 32'(res_slot), 32'(er.slot));
            check("res_value", 32'(res_port(res_slot)), 32'(er.data));
         end else begin
            check("unexpected_res_vld", 32'(res_vld), 32'd0);
         end
      end
      if (idle_phase) check("busy_when_disabled", 32'(busy), 32'd0);
   endtask

   task automatic wait_drain(input int budget);
      int n;
      n = 0;
      while ((exp_cmd_q.size() > 0 || exp_res_q.size() > 0) && n < budget) begin
         tick();
         n++;
      end
      check("drain_cmd_q", 32'(exp_cmd_q.size()), 32'd0);
      check("drain_res_q", 32'(exp_res_q.size()), 32'd0);
   endtask

   task automatic pulse_rst();
      rst = 1'b1;
      tick();
      tick();
      rst = 1'b0;
   endtask

   initial begin
      int n;
      n_checks    = 0;
      n_errors    = 0;
      cyc         = 0;
      last_first  = -1;
      first_par   = 1'b1;
      chk_spacing = 1'b1;
      idle_phase  = 1'b0;
      hold_rd     = 1'b0;
      done_man    = 1'b0;
      rst         = 1'b1;
      en_mask     = 4'hF;
      dmd_vld     = 1'b0;
      dmd_slot    = 2'd0;

      // Reset state
      tick();
      tick();
      check("rst_wrt", 32'(bus.wrt), 32'd0);
      check("rst_cmd", 32'(bus.cmd), 32'd0);
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_res_vld", 32'(res_vld), 32'd0);
      check("rst_res_slot", 32'(res_slot), 32'd0);
      check("rst_batt", 32'(batt), 32'd0);
      check("rst_curr", 32'(curr), 32'd0);
      check("rst_brake", 32'(brake), 32'd0);
      check("rst_torque", 32'(torque), 32'd0);
      check("rst_dmd_rdy", 32'(dmd_rdy), 32'd1);
      rst = 1'b0;

      // Full round robin, slots 0..3
      for (int s = 0; s < 4; s++) push_conv(s);
      wait_drain(400);
      check("rr_batt", 32'(batt), 32'hC00);
      check("rr_curr", 32'(curr), 32'hBF1);
      check("rr_brake", 32'(brake), 32'hBE3);
      check("rr_torque", 32'(torque), 32'hBD4);

      // Sparse mask 1010 from reset: slots 1,3,1,3 only
      pulse_rst();
      en_mask    = 4'b1010;
      last_first = -1;
      push_conv(1); push_conv(3); push_conv(1); push_conv(3);
      wait_drain(400);
      check("mask_batt_zero", 32'(batt), 32'd0);
      check("mask_brake_zero", 32'(brake), 32'd0);
      check("mask_curr", 32'(curr), 32'hBF1);
      chk_spacing = 1'b0;

      // Demand on the due cycle wins; rr pointer still points at slot 3 afterwards
      repeat (P) tick();
      dmd_vld  = 1'b1;
      dmd_slot = 2'd2;
      check("dmd_rdy_when_due", 32'(dmd_rdy), 32'd1);
      check("busy_before_dmd", 32'(busy), 32'd0);
      push_conv(2);
      push_conv(1);
      tick();
      dmd_vld = 1'b0;
      check("dmd_brake_in_flight", 32'(busy), 32'd1);
      wait_drain(200);
      check("dmd_brake", 32'(brake), 32'hBE3);

      // Demand raised during WAIT1 waits for IDLE, then goes before the schedule
      push_conv(3);
      n = 0;
      while (bus.wrt !== 1'b1 && n < 200) begin tick(); n++; end
      check("sched_wrt_seen", 32'(bus.wrt), 32'd1);
      tick();
      dmd_vld  = 1'b1;
      dmd_slot = 2'd0;
      check("dmd_rdy_in_wait1", 32'(dmd_rdy), 32'd0);
      push_conv(0);
      n = 0;
      while (dmd_rdy !== 1'b1 && n < 50) begin tick(); n++; end
      check("dmd_rdy_back_in_idle", 32'(dmd_rdy), 32'd1);
      check("accept_on_first_idle", 32'(res_vld), 32'd1);
      tick();
      dmd_vld = 1'b0;
      wait_drain(100);

      // Reset while in WAIT2; a later done must not land a result
      hold_rd = 1'b1;
      push_conv(1, 1'b0);
      n = 0;
      while (exp_cmd_q.size() > 0 && n < 200) begin tick(); n++; end
      check("wait2_cmds_seen", 32'(exp_cmd_q.size()), 32'd0);
      tick();
      tick();
      check("in_wait2_busy", 32'(busy), 32'd1);
      rst = 1'b1;
      tick();
      rst     = 1'b0;
      hold_rd = 1'b0;
      check("post_rst_busy", 32'(busy), 32'd0);
      done_man = 1'b1;
      tick();
      done_man = 1'b0;
      repeat (3) tick();
      check("post_rst_batt", 32'(batt), 32'd0);
      check("post_rst_curr", 32'(curr), 32'd0);
      check("post_rst_brake", 32'(brake), 32'd0);
      check("post_rst_torque", 32'(torque), 32'd0);
      en_mask = 4'hF;
      push_conv(0);
      wait_drain(100);
      check("post_rst_first_batt", 32'(batt), 32'hC00);
      check("post_rst_curr_still0", 32'(curr), 32'd0);

      // Empty mask: nothing scheduled, spurious done ignored
      en_mask    = 4'h0;
      idle_phase = 1'b1;
      for (int i = 0; i < 5 * P; i++) begin
         done_man = ((i % 7) == 3);
         tick();
      end
      done_man   = 1'b0;
      idle_phase = 1'b0;
      check("disabled_busy", 32'(busy), 32'd0);
      check("disabled_torque_hold", 32'(torque), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
